// File: rtl/spi_flash_reader.sv
// SPI flash READ (0x03) initiator: shifts out {opcode, 24-bit address}, then shifts in 1..256 bytes.
// Latency: csb low for CLK_DIV*(2 + 2*(32 + 8*(len+1))) cycles; each byte appears one cycle after its last bit is sampled.
// Backpressure: req_ready is high only in IDLE; rd_valid cannot be stalled, so the consumer must take every byte.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV  = 2,      // clk cycles per SCK half-period, legal 2..255
    parameter logic [7:0]  CMD_READ = 8'h03   // opcode shifted out first
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Last count value of the half-period divider.
    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    // Command plus address occupy the first 32 bit slots; data bits follow.
    localparam logic [11:0] ADDR_BITS = 12'd32;
    // Index of the last bit for a one-byte read; each extra byte adds eight.
    localparam logic [11:0] LAST_BASE = 12'd39;

    state_t      state_q,    state_d;
    logic [7:0]  div_q,      div_d;
    logic [11:0] bit_q,      bit_d;
    logic [11:0] last_bit_q, last_bit_d;
    logic [31:0] tx_q,       tx_d;
    logic [6:0]  rx_q,       rx_d;
    logic [7:0]  rd_data_q,  rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q,     done_d;
    logic        busy_q,     busy_d;
    logic        req_ready_q, req_ready_d;
    logic        csb_q,      csb_d;
    logic        sck_q,      sck_d;
    logic        io0_q,      io0_d;

    logic        div_end;
    logic        data_bit;
    logic        accept;

    // Divider reaches the end of the current half-period (or SETUP/HOLD/GAP window).
    assign div_end  = (div_q == DIV_LAST);
    // Bit slots from 32 onward belong to the data phase; address bits never load rx.
    assign data_bit = (bit_q >= ADDR_BITS);
    assign accept   = req_valid && req_ready_q;

    // Next-state and next-output computation for the whole transfer sequence.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        last_bit_d  = last_bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy_q;
        req_ready_d = req_ready_q;
        csb_d       = csb_q;
        sck_d       = sck_q;
        io0_d       = io0_q;

        unique case (state_q)
            ST_IDLE: begin
                csb_d       = 1'b1;
                sck_d       = 1'b0;
                io0_d       = 1'b0;
                busy_d      = 1'b0;
                req_ready_d = 1'b1;
                if (accept) begin
                    // Everything the transfer needs is captured here; later
                    // changes on req_addr/req_len cannot disturb it.
                    state_d     = ST_SETUP;
                    tx_d        = {CMD_READ, req_addr};
                    last_bit_d  = LAST_BASE + {1'b0, req_len, 3'b000};
                    div_d       = 8'd0;
                    bit_d       = 12'd0;
                    csb_d       = 1'b0;
                    io0_d       = CMD_READ[7];
                    busy_d      = 1'b1;
                    req_ready_d = 1'b0;
                end
            end

            ST_SETUP: begin
                // First bit is presented for a full half-period before the
                // first low phase so the flash sees it well ahead of SCK rise.
                io0_d = tx_q[31];
                if (div_end) begin
                    div_d   = 8'd0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            ST_SHIFT: begin
                if (!sck_q) begin
                    // Low phase: io0 already stable, just time out the half-period.
                    if (div_end) begin
                        div_d = 8'd0;
                        sck_d = 1'b1;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end else begin
                    // High phase: sample MISO once, at the end of its first cycle.
                    if ((div_q == 8'd0) && data_bit) begin
                        rx_d = {rx_q[5:0], flash_io1};
                        if (bit_q[2:0] == 3'd7) begin
                            rd_data_d  = {rx_q, flash_io1};
                            rd_valid_d = 1'b1;
                        end
                    end
                    if (div_end) begin
                        div_d = 8'd0;
                        sck_d = 1'b0;
                        if (bit_q == last_bit_q) begin
                            state_d = ST_HOLD;
                            io0_d   = 1'b0;
                        end else begin
                            // Falling edge: advance to the next bit; zeros shift
                            // in behind the address so MOSI is low in the data phase.
                            bit_d = bit_q + 12'd1;
                            tx_d  = {tx_q[30:0], 1'b0};
                            io0_d = tx_q[30];
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
            end

            ST_HOLD: begin
                // Keep the chip selected with SCK low after the last rising edge.
                if (div_end) begin
                    div_d   = 8'd0;
                    state_d = ST_GAP;
                    csb_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            ST_GAP: begin
                // Deselect time before another command may start.
                if (div_end) begin
                    div_d       = 8'd0;
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                csb_d   = 1'b1;
                sck_d   = 1'b0;
                io0_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset deselects the flash immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= 8'd0;
            bit_q       <= 12'd0;
            last_bit_q  <= 12'd0;
            tx_q        <= 32'd0;
            rx_q        <= 7'd0;
            rd_data_q   <= 8'd0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b0;
            csb_q       <= 1'b1;
            sck_q       <= 1'b0;
            io0_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            last_bit_q  <= last_bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            csb_q       <= csb_d;
            sck_q       <= sck_d;
            io0_q       <= io0_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign flash_csb = csb_q;
    assign flash_clk = sck_q;
    assign flash_io0 = io0_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: two instances (CLK_DIV 2 and 5), each with a mode-0 flash model.
// Flash content is a fixed function of address; every byte is checked against it.
// Timing, select window, SCK widths and pulse counts are checked against hand-derived values.
module tb_spi_flash_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Flash content model.
    function automatic logic [7:0] fb(input logic [23:0] a);
        return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h5B;
    endfunction

    function automatic logic model_bit(input logic [23:0] a, input int c);
        logic [7:0] b;
        b = fb(a + 24'(c / 8));
        return b[3'(7 - (c % 8))];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- instance A: CLK_DIV = 2 ----------------
    logic        req_valid_a = 1'b0, req_ready_a, rd_valid_a, busy_a, done_a;
    logic [23:0] req_addr_a = 24'd0;
    logic [7:0]  req_len_a = 8'd0, rd_data_a;
    logic        csb_a, sck_a, io0_a, io1_a = 1'b0;

    spi_flash_reader #(.CLK_DIV(2), .CMD_READ(8'h03)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_addr(req_addr_a), .req_len(req_len_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .busy(busy_a), .done(done_a), .flash_csb(csb_a), .flash_clk(sck_a),
        .flash_io0(io0_a), .flash_io1(io1_a)
    );

    logic [31:0] sh_a = 32'd0, cmd_a = 32'd0;
    int cnt_a = 0, rises_a = 0;
    always @(posedge sck_a or posedge csb_a) begin
        if (csb_a) begin
            rises_a <= cnt_a;
            cnt_a   <= 0;
        end else begin
            sh_a  <= {sh_a[30:0], io0_a};
            if (cnt_a == 31) cmd_a <= {sh_a[30:0], io0_a};
            cnt_a <= cnt_a + 1;
        end
    end
    always @(negedge sck_a) begin
        if (!csb_a && cnt_a >= 32) io1_a <= model_bit(cmd_a[23:0], cnt_a - 32);
    end

    logic [7:0] got_a [0:63];
    int n_a = 0, done_n_a = 0, done_bad_a = 0, lo_run_a = 0, low_a = 0;
    int hi_run_a = 0, gap_a = 0, n_sel_a = 0;
    bit csb_prev_a = 1'b0;
    always @(negedge clk) begin
        if (rd_valid_a) begin
            got_a[n_a & 63] <= rd_data_a;
            n_a <= n_a + 1;
        end
        if (done_a) begin
            done_n_a <= done_n_a + 1;
            if (!csb_a) done_bad_a <= done_bad_a + 1;
        end
        if (!csb_a) begin
            lo_run_a <= lo_run_a + 1;
            if (csb_prev_a) begin
                gap_a   <= hi_run_a;
                n_sel_a <= n_sel_a + 1;
            end
            hi_run_a <= 0;
        end else begin
            hi_run_a <= hi_run_a + 1;
            if (lo_run_a != 0) low_a <= lo_run_a;
            lo_run_a <= 0;
        end
        csb_prev_a <= csb_a;
    end

    // ---------------- instance B: CLK_DIV = 5 ----------------
    logic        req_valid_b = 1'b0, req_ready_b, rd_valid_b, busy_b, done_b;
    logic [23:0] req_addr_b = 24'd0;
    logic [7:0]  req_len_b = 8'd0, rd_data_b;
    logic        csb_b, sck_b, io0_b, io1_b = 1'b0;

    spi_flash_reader #(.CLK_DIV(5), .CMD_READ(8'h03)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr_b), .req_len(req_len_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .busy(busy_b), .done(done_b), .flash_csb(csb_b), .flash_clk(sck_b),
        .flash_io0(io0_b), .flash_io1(io1_b)
    );

    logic [31:0] sh_b = 32'd0, cmd_b = 32'd0;
    int cnt_b = 0, rises_b = 0;
    always @(posedge sck_b or posedge csb_b) begin
        if (csb_b) begin
            rises_b <= cnt_b;
            cnt_b   <= 0;
        end else begin
            sh_b  <= {sh_b[30:0], io0_b};
            if (cnt_b == 31) cmd_b <= {sh_b[30:0], io0_b};
            cnt_b <= cnt_b + 1;
        end
    end
    always @(negedge sck_b) begin
        if (!csb_b && cnt_b >= 32) io1_b <= model_bit(cmd_b[23:0], cnt_b - 32);
    end

    logic [7:0] got_b [0:255];
    int cyc = 0;
    int n_b = 0, done_n_b = 0, last_rv_b = 0, sp_bad_b = 0, w_bad_b = 0, run_b = 0;
    int lo_run_b = 0, low_b = 0;
    bit sck_prev_b = 1'b0, seen_hi_b = 1'b0;
    always @(negedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rd_valid_b) begin
            got_b[n_b & 255] <= rd_data_b;
            n_b <= n_b + 1;
            if (n_b != 0 && (cyc - last_rv_b) != 80) sp_bad_b <= sp_bad_b + 1;
            last_rv_b <= cyc;
        end
        if (done_b) done_n_b <= done_n_b + 1;
        if (!csb_b) lo_run_b <= lo_run_b + 1;
        else begin
            if (lo_run_b != 0) low_b <= lo_run_b;
            lo_run_b <= 0;
        end
        if (sck_b == sck_prev_b) run_b <= run_b + 1;
        else begin
            if (sck_prev_b && run_b != 5) w_bad_b <= w_bad_b + 1;
            if (!sck_prev_b && seen_hi_b && run_b != 5) w_bad_b <= w_bad_b + 1;
            run_b <= 1;
        end
        if (csb_b) seen_hi_b <= 1'b0;
        else if (sck_b) seen_hi_b <= 1'b1;
        sck_prev_b <= sck_b;
    end

    // ---------------- helpers ----------------
    task automatic start_a(input logic [23:0] addr, input logic [7:0] len);
        for (int i = 0; i < 100 && !req_ready_a; i++) @(negedge clk);
        chk("ready_timeout", 32'(req_ready_a), 32'd1);
        req_addr_a  = addr;
        req_len_a   = len;
        req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        req_addr_a  = 24'hABCDEF;
        req_len_a   = 8'hFF;
        chk("accept_busy", {29'd0, busy_a, req_ready_a, csb_a}, 32'b100);
    endtask

    task automatic wait_done_a(input int target);
        for (int i = 0; i < 40000 && done_n_a < target; i++) @(negedge clk);
        chk("done_timeout_a", 32'(done_n_a >= target), 32'd1);
    endtask

    int base, dn, nv, sel0;

    initial begin
        // Reset state while reset is held
        repeat (3) @(negedge clk);
        chk("rst_csb", 32'(csb_a), 32'd1);
        chk("rst_sck", 32'(sck_a), 32'd0);
        chk("rst_io0", 32'(io0_a), 32'd0);
        chk("rst_rd_data", 32'(rd_data_a), 32'd0);
        chk("rst_ctrl", {28'd0, rd_valid_a, done_a, busy_a, req_ready_a}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready_a), 32'd1);

        // 1: addr 0, one byte
        base = n_a; dn = done_n_a;
        start_a(24'h000000, 8'd0);
        wait_done_a(dn + 1);
        repeat (4) @(negedge clk);
        chk("t1_cmd", cmd_a, 32'h03000000);
        chk("t1_rises", 32'(rises_a), 32'd40);
        chk("t1_csb_low", 32'(low_a), 32'd164);
        chk("t1_nbytes", 32'(n_a - base), 32'd1);
        chk("t1_byte", 32'(got_a[base & 63]), 32'(fb(24'h000000)));
        chk("t1_done_cnt", 32'(done_n_a - dn), 32'd1);
        chk("t1_idle", {30'd0, busy_a, req_ready_a}, 32'b01);

        // 2: addr 0x10, four bytes
        base = n_a; dn = done_n_a;
        start_a(24'h000010, 8'd3);
        wait_done_a(dn + 1);
        repeat (4) @(negedge clk);
        chk("t2_cmd", cmd_a, 32'h03000010);
        chk("t2_rises", 32'(rises_a), 32'd64);
        chk("t2_csb_low", 32'(low_a), 32'd260);
        chk("t2_nbytes", 32'(n_a - base), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t2_byte", 32'(got_a[(base + i) & 63]), 32'(fb(24'h000010 + 24'(i))));

        // 3: req_valid held high for the whole transfer
        for (int i = 0; i < 100 && !req_ready_a; i++) @(negedge clk);
        base = n_a; dn = done_n_a; sel0 = n_sel_a;
        req_addr_a = 24'h000020; req_len_a = 8'd1; req_valid_a = 1'b1;
        wait_done_a(dn + 1);
        req_valid_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("t3_one_xfer", 32'(n_sel_a - sel0), 32'd1);
        chk("t3_nbytes", 32'(n_a - base), 32'd2);
        chk("t3_byte0", 32'(got_a[base & 63]), 32'(fb(24'h000020)));
        chk("t3_byte1", 32'(got_a[(base + 1) & 63]), 32'(fb(24'h000021)));

        // 4: reset during the data phase of an 8-byte read
        base = n_a;
        start_a(24'h000040, 8'd7);
        for (int i = 0; i < 2000 && n_a < base + 3; i++) @(negedge clk);
        chk("t4_reach_data", 32'(n_a >= base + 3), 32'd1);
        reset = 1'b1;
        #1;
        chk("t4_rst_pins", {29'd0, csb_a, sck_a, io0_a}, 32'b100);
        chk("t4_rst_ctrl", {28'd0, rd_valid_a, done_a, busy_a, req_ready_a}, 32'd0);
        @(negedge clk);
        nv = n_a; dn = done_n_a;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("t4_no_rv", 32'(n_a - nv), 32'd0);
        chk("t4_no_done", 32'(done_n_a - dn), 32'd0);
        base = n_a;
        start_a(24'h000040, 8'd7);
        wait_done_a(dn + 1);
        repeat (4) @(negedge clk);
        chk("t4_nbytes", 32'(n_a - base), 32'd8);
        for (int i = 0; i < 8; i++)
            chk("t4_byte", 32'(got_a[(base + i) & 63]), 32'(fb(24'h000040 + 24'(i))));

        // 6: back-to-back requests 0x100 then 0x200
        for (int i = 0; i < 100 && !req_ready_a; i++) @(negedge clk);
        base = n_a; dn = done_n_a; sel0 = n_sel_a;
        req_addr_a = 24'h000100; req_len_a = 8'd1; req_valid_a = 1'b1;
        for (int i = 0; i < 100 && n_sel_a < sel0 + 1; i++) @(negedge clk);
        req_addr_a = 24'h000200;
        for (int i = 0; i < 2000 && n_sel_a < sel0 + 2; i++) @(negedge clk);
        req_valid_a = 1'b0;
        chk("t6_second_sel", 32'(n_sel_a - sel0), 32'd2);
        chk("t6_gap", 32'(gap_a >= 2), 32'd1);
        wait_done_a(dn + 2);
        repeat (4) @(negedge clk);
        chk("t6_cmd2", cmd_a, 32'h03000200);
        chk("t6_nbytes", 32'(n_a - base), 32'd4);
        chk("t6_b0", 32'(got_a[base & 63]), 32'(fb(24'h000100)));
        chk("t6_b1", 32'(got_a[(base + 1) & 63]), 32'(fb(24'h000101)));
        chk("t6_b2", 32'(got_a[(base + 2) & 63]), 32'(fb(24'h000200)));
        chk("t6_b3", 32'(got_a[(base + 3) & 63]), 32'(fb(24'h000201)));
        chk("t6_done_ok", 32'(done_bad_a), 32'd0);

        // 5: CLK_DIV = 5, 256 bytes
        for (int i = 0; i < 100 && !req_ready_b; i++) @(negedge clk);
        chk("t5_ready", 32'(req_ready_b), 32'd1);
        req_addr_b = 24'h0ABCF0; req_len_b = 8'd255; req_valid_b = 1'b1;
        @(negedge clk);
        req_valid_b = 1'b0;
        for (int i = 0; i < 30000 && done_n_b < 1; i++) @(negedge clk);
        chk("t5_done", 32'(done_n_b), 32'd1);
        repeat (8) @(negedge clk);
        chk("t5_rises", 32'(rises_b), 32'd2080);
        chk("t5_csb_low", 32'(low_b), 32'd20810);
        chk("t5_nbytes", 32'(n_b), 32'd256);
        chk("t5_spacing", 32'(sp_bad_b), 32'd0);
        chk("t5_sck_width", 32'(w_bad_b), 32'd0);
        for (int i = 0; i < 256; i++)
            chk("t5_byte", 32'(got_b[i]), 32'(fb(24'h0ABCF0 + 24'(i))));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
